// File: rtl/sha256_nonce_sched.sv
// Nonce-search job controller: walks a nonce range through a single-block SHA-256 core and
// reports the first digest below target. Define SHA_SCHED_TIMEOUT_EN for the core_done watchdog.
module sha256_nonce_sched #(
`ifdef SHA_SCHED_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYC = 255,
`endif
   parameter int unsigned NONCE_LSB   = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [511:0] job_msg,
   input  logic [31:0]  job_nonce_start,
   input  logic [31:0]  job_nonce_end,
   input  logic [255:0] job_target,
   input  logic         abort,
   output logic         core_start,
   output logic [511:0] core_data_in,
   input  logic [255:0] core_data_out,
   input  logic         core_done,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         res_found,
   output logic [31:0]  res_nonce,
   output logic [255:0] res_digest,
   output logic         busy,
   output logic         timeout_err
);

   typedef enum logic [3:0] {
      StIdle,
      StLoad,
      StStart,
      StClr,
      StRun,
      StSettle,
      StCheck,
      StReport,
      StDrain,
      StDrainWait
   } state_e;

   state_e        state_q;
   logic [511:0]  msg_q;
   logic [255:0]  target_q;
   logic [31:0]   nonce_cur_q;
   logic [31:0]   nonce_end_q;
   logic          abort_pend_q;

   logic [511:0]  msg_nonce;
   logic          hit;
   logic          tmo_fire;

   always_comb begin
      msg_nonce = msg_q;
      msg_nonce[NONCE_LSB +: 32] = nonce_cur_q;
   end

   assign hit = (core_data_out < target_q);

`ifdef SHA_SCHED_TIMEOUT_EN
   localparam int unsigned TmoBits = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned TmoW    = (TmoBits > 8) ? TmoBits : 8;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

   logic [TmoW-1:0] tmo_cnt_q;
   logic            tmo_run;

   assign tmo_run = (state_q == StClr) || (state_q == StRun) || (state_q == StDrain);

   // A done seen in RUN/DRAIN wins over a watchdog expiring in the same cycle.
   always_comb begin
      tmo_fire = 1'b0;
      if (tmo_cnt_q == TmoLast) begin
         if (state_q == StClr) begin
            tmo_fire = 1'b1;
         end else if ((state_q == StRun || state_q == StDrain) && !core_done) begin
            tmo_fire = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q   <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state_q == StStart) begin
            tmo_cnt_q <= '0;
         end else if (tmo_run) begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
         end
         if (state_q == StIdle && job_valid && job_ready) begin
            timeout_err <= 1'b0;
         end else if (tmo_fire) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign tmo_fire    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         msg_q        <= '0;
         target_q     <= '0;
         nonce_cur_q  <= '0;
         nonce_end_q  <= '0;
         abort_pend_q <= 1'b0;
         job_ready    <= 1'b0;
         busy         <= 1'b0;
         core_start   <= 1'b0;
         core_data_in <= '0;
         res_valid    <= 1'b0;
         res_found    <= 1'b0;
         res_nonce    <= '0;
         res_digest   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               job_ready <= 1'b1;
               if (job_valid && job_ready) begin
                  msg_q        <= job_msg;
                  target_q     <= job_target;
                  nonce_cur_q  <= job_nonce_start;
                  nonce_end_q  <= job_nonce_end;
                  abort_pend_q <= 1'b0;
                  res_found    <= 1'b0;
                  job_ready    <= 1'b0;
                  busy         <= 1'b1;
                  state_q      <= StLoad;
               end
            end

            StLoad: begin
               if (abort) begin
                  res_valid <= 1'b1;
                  res_found <= 1'b0;
                  res_nonce <= nonce_cur_q;
                  state_q   <= StReport;
               end else begin
                  core_data_in <= msg_nonce;
                  core_start   <= 1'b1;
                  state_q      <= StStart;
               end
            end

            // The start pulse is already out; an abort here must still drain the core.
            StStart: begin
               core_start <= 1'b0;
               if (abort) begin
                  abort_pend_q <= 1'b1;
               end
               state_q <= StClr;
            end

            StClr: begin
               if (tmo_fire) begin
                  res_valid <= 1'b1;
                  res_found <= 1'b0;
                  res_nonce <= nonce_cur_q;
                  state_q   <= StReport;
               end else if (abort || abort_pend_q) begin
                  state_q <= StDrain;
               end else begin
                  state_q <= StRun;
               end
            end

            StRun: begin
               if (tmo_fire) begin
                  res_valid <= 1'b1;
                  res_found <= 1'b0;
                  res_nonce <= nonce_cur_q;
                  state_q   <= StReport;
               end else if (abort) begin
                  state_q <= StDrain;
               end else if (core_done) begin
                  state_q <= StSettle;
               end
            end

            StSettle: begin
               state_q <= abort ? StDrain : StCheck;
            end

            StCheck: begin
               res_digest <= core_data_out;
               if (abort || hit || (nonce_cur_q == nonce_end_q)) begin
                  res_valid <= 1'b1;
                  res_found <= hit && !abort;
                  res_nonce <= nonce_cur_q;
                  state_q   <= StReport;
               end else begin
                  nonce_cur_q <= nonce_cur_q + 32'd1;
                  state_q     <= StLoad;
               end
            end

            StDrain: begin
               if (tmo_fire) begin
                  res_valid <= 1'b1;
                  res_found <= 1'b0;
                  res_nonce <= nonce_cur_q;
                  state_q   <= StReport;
               end else if (core_done) begin
                  state_q <= StDrainWait;
               end
            end

            // Digest of the aborted nonce is valid here, so report it.
            StDrainWait: begin
               res_digest <= core_data_out;
               res_valid  <= 1'b1;
               res_found  <= 1'b0;
               res_nonce  <= nonce_cur_q;
               state_q    <= StReport;
            end

            StReport: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  job_ready <= 1'b1;
                  state_q   <= StIdle;
               end
            end

            default: begin
               core_start <= 1'b0;
               res_valid  <= 1'b0;
               busy       <= 1'b0;
               job_ready  <= 1'b0;
               state_q    <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/sha256_nonce_sched.md
Name: sha256_nonce_sched

Overview:
- Job controller that sequences the single-block SHA-256 core for nonce search.
- Accepts a 512-bit message template, a nonce range and a 256-bit target.
- For each nonce: inserts the nonce into the template, starts the core, waits for its digest, and compares the digest against the target.
- Returns the first nonce with digest < target, or reports range exhaustion. Sits between the host register/job interface and the core.

Parameters:
- NONCE_LSB, 0: bit position of the 32-bit nonce field inside the 512-bit message.
- TIMEOUT_CYC, 255: watchdog limit in cycles from core_start to core_done; used only with SHA_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  scheduler can accept a job (high only in IDLE)
- job_msg  in  512  message template; the nonce field is overwritten
- job_nonce_start  in  32  first nonce
- job_nonce_end  in  32  last nonce, inclusive
- job_target  in  256  unsigned threshold
- abort  in  1  cancel the current job
- core_start  out  1  one-cycle start pulse to the core
- core_data_in  out  512  message to the core
- core_data_out  in  256  core digest
- core_done  in  1  core completion level
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_found  out  1  1 = hit, 0 = exhausted or aborted
- res_nonce  out  32  hit nonce, otherwise last nonce hashed
- res_digest  out  256  digest of res_nonce
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag (optional feature only)

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE; job_ready becomes 1 on the first clock after reset deasserts.
- Core contract:
  - core_done falls on the cycle after core_start.
  - core_done later rises and stays high until the next start.
  - core_data_out becomes valid one cycle after core_done rises.
  - core_data_in must be held stable from core_start until the digest is captured.
- FSM states:
  - IDLE: job_ready=1. On job_valid, latch msg, target, nonce_cur=start and end; go to LOAD.
  - LOAD: core_data_in = msg with bits [NONCE_LSB+:32] replaced by nonce_cur; go to START.
  - START: core_start=1 for exactly one cycle; go to CLR.
  - CLR: ignore core_done for one cycle; go to RUN.
  - RUN: wait for core_done=1; go to SETTLE.
  - SETTLE: one-cycle wait; go to CHECK.
  - CHECK:
    - Capture core_data_out into res_digest.
    - hit = (core_data_out < target), 256-bit unsigned compare.
    - If hit: go to REPORT with res_found=1.
    - Else if nonce_cur == end: go to REPORT with res_found=0.
    - Else: nonce_cur += 1 (mod 2^32) and go to LOAD.
  - REPORT: res_valid=1 with res_found, res_nonce, res_digest held stable. On res_valid && res_ready, go to IDLE (job_ready=1 the next cycle).
- Range rules:
  - start == end: exactly one hash.
  - end < start: search wraps through 0xFFFFFFFF to 0.
  - The full 2^32 range is expressed as end = start-1.
- Per-hash overhead: 5 cycles plus core latency.
- Abort:
  - In LOAD or CHECK: go directly to REPORT with res_found=0, res_nonce=nonce_cur.
  - In START, CLR, RUN or SETTLE: go to DRAIN, which waits for core_done=1, then one extra cycle, then goes to REPORT with res_found=0, res_nonce=nonce_cur.
  - In IDLE or REPORT: ignored.
- A job offered in the same cycle as the REPORT handshake is not accepted; job_ready rises the next cycle.
- core_start is never asserted outside START.
- Asserting reset mid-job: immediately returns the FSM to IDLE and clears res_valid and core_start. The core is expected to be reset by the same reset.

Optional Feature:
- SHA_SCHED_TIMEOUT_EN defined:
  - An 8+ bit counter runs in CLR, RUN and DRAIN.
  - Reaching TIMEOUT_CYC sets timeout_err (sticky until reset or the next accepted job) and goes to REPORT with res_found=0 and res_nonce=nonce_cur.
- SHA_SCHED_TIMEOUT_EN undefined:
  - No counter; timeout_err is tied to 0.
  - RUN and DRAIN wait indefinitely.

Test Plan:
- Target = all-ones, start = end = 0x00000010 (behavioural core model) -> one core_start, res_found=1, res_nonce=0x00000010, res_digest equals model digest.
- Target = 0, start = 5, end = 7 -> exactly 3 core_start pulses with nonce field 5, 6, 7; res_found=0, res_nonce=7.
- Target = 0, start = 0xFFFFFFFE, end = 1 -> nonces 0xFFFFFFFE, 0xFFFFFFFF, 0, 1 in that order; res_found=0, res_nonce=1.
- Model digest < target only for nonce 0x22, range 0x20..0x30 -> res_found=1, res_nonce=0x22, exactly 3 core_start pulses.
- abort asserted during RUN of the 2nd hash of range 0..9 -> no further core_start; REPORT only after core_done; res_found=0, res_nonce=1.
- With SHA_SCHED_TIMEOUT_EN and a core model that never raises done -> timeout_err=1 exactly TIMEOUT_CYC cycles after CLR entry; res_found=0; res_ready/job_valid then accepts a new job.
